// File: rtl/alp_param_pkg.sv
// Op codes, FSM states and iterative-unit modes shared by the ALP compute core.
// Types and constants only; no logic, no latency, no flow control.
package alp_param_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_SWAP = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_DIV  = 3'b101;
  localparam logic [2:0] OP_CLRR = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

  typedef enum logic [1:0] {IDLE, INIT, ITER, DONE} state_t;

  typedef enum logic {MODE_MUL, MODE_DIV} mode_t;

endpackage

// File: rtl/alp_param_if.sv
// Command/result bundle between the board controls and the ALP core.
// Plain level signals; the core ignores load/comp while busy is high.
interface alp_param_if #(parameter int WIDTH = 4);

  logic [WIDTH-1:0] data_in;
  logic [2:0]       op;
  logic             load;
  logic             comp;
  logic             clr;
  logic [WIDTH-1:0] out_0;
  logic [WIDTH-1:0] out_1;
  logic             err;
  logic             busy;
  logic             done;

  modport master (
    output data_in, op, load, comp, clr,
    input  out_0, out_1, err, busy, done
  );

  modport slave (
    input  data_in, op, load, comp, clr,
    output out_0, out_1, err, busy, done
  );

endinterface

// File: rtl/alp_iter_unit.sv
// One combinational step of signed Booth multiply or unsigned restoring divide.
// Zero latency, no flow control; the caller registers A/Q/q_n1 between steps.
module alp_iter_unit
  import alp_param_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_m,
  input  logic             i_q_n1,
  input  mode_t            i_mode,
  output logic [WIDTH:0]   o_a,
  output logic [WIDTH-1:0] o_q,
  output logic             o_q_n1
);

  logic [WIDTH:0]   w_m_sx;
  logic [WIDTH:0]   w_m_zx;
  logic [WIDTH:0]   w_a_bth;
  logic [WIDTH:0]   w_a_sh;
  logic [WIDTH:0]   w_a_try;
  logic [WIDTH-1:0] w_q_sh;

  // A carries one guard bit so Booth never overflows when M is the most negative value.
  always_comb begin
    w_m_sx  = {i_m[WIDTH-1], i_m};
    w_m_zx  = {1'b0, i_m};
    w_a_bth = i_a;
    w_a_sh  = {i_a[WIDTH-1:0], i_q[WIDTH-1]};
    w_q_sh  = {i_q[WIDTH-2:0], 1'b0};
    w_a_try = w_a_sh - w_m_zx;
    o_a     = i_a;
    o_q     = i_q;
    o_q_n1  = i_q_n1;
    if (i_mode == MODE_MUL) begin
      case ({i_q[0], i_q_n1})
        2'b01:   w_a_bth = i_a + w_m_sx;
        2'b10:   w_a_bth = i_a - w_m_sx;
        default: w_a_bth = i_a;
      endcase
      o_a    = {w_a_bth[WIDTH], w_a_bth[WIDTH:1]};
      o_q    = {w_a_bth[0], i_q[WIDTH-1:1]};
      o_q_n1 = i_q[0];
    end else if (w_a_try[WIDTH]) begin
      o_a = w_a_sh;
      o_q = w_q_sh;
    end else begin
      o_a = w_a_try;
      o_q = {i_q[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/alp_param.sv
// ALP core: R0/R1 with single-cycle add/sub/swap/clear and WIDTH-step Booth multiply / restoring divide.
// Single-cycle ops finish at the accept edge; MUL/DIV hold busy for WIDTH+1 cycles, commands ignored meanwhile.
module alp_param
  import alp_param_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input logic        clk,
  input logic        rst_n,
  alp_param_if.slave bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_r0;
  logic [WIDTH-1:0] r_r1;
  logic             r_err;
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic             r_qn1;
  logic [CNT_W-1:0] r_cnt;
  mode_t            r_mode;

  logic [WIDTH:0]   w_a_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_qn1_nxt;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_dif;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic             w_idle;
  logic             w_do_comp;
  logic             w_do_load;
  logic             w_iter_op;
  logic             w_last;

  alp_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .i_a    (r_a),
    .i_q    (r_q),
    .i_m    (r_m),
    .i_q_n1 (r_qn1),
    .i_mode (r_mode),
    .o_a    (w_a_nxt),
    .o_q    (w_q_nxt),
    .o_q_n1 (w_qn1_nxt)
  );

  always_comb begin
    w_sum     = r_r0 + r_r1;
    w_dif     = r_r0 - r_r1;
    w_add_ovf = (r_r0[WIDTH-1] == r_r1[WIDTH-1]) && (w_sum[WIDTH-1] != r_r0[WIDTH-1]);
    w_sub_ovf = (r_r0[WIDTH-1] != r_r1[WIDTH-1]) && (w_dif[WIDTH-1] != r_r0[WIDTH-1]);
    w_idle    = (r_state == IDLE) || (r_state == DONE);
    w_do_comp = w_idle && bus.comp;
    w_do_load = w_idle && bus.load && !bus.comp;
    // Divide by zero is reported immediately instead of iterating.
    w_iter_op = (bus.op == OP_MUL) || ((bus.op == OP_DIV) && (r_r1 != '0));
    w_last    = (r_state == ITER) && (r_cnt == CNT_W'(1));
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_do_comp) w_state_nxt = w_iter_op ? INIT : DONE;
        else           w_state_nxt = IDLE;
      end
      INIT:    w_state_nxt = ITER;
      ITER:    if (w_last) w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
    if (bus.clr) w_state_nxt = IDLE;
    bus.busy  = (r_state == INIT) || (r_state == ITER);
    bus.done  = (r_state == DONE);
    bus.out_0 = r_r0;
    bus.out_1 = r_r1;
    bus.err   = r_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r0   <= '0;
      r_r1   <= '0;
      r_err  <= 1'b0;
      r_a    <= '0;
      r_q    <= '0;
      r_m    <= '0;
      r_qn1  <= 1'b0;
      r_cnt  <= '0;
      r_mode <= MODE_MUL;
    end else if (bus.clr) begin
      r_r0   <= '0;
      r_r1   <= '0;
      r_err  <= 1'b0;
      r_a    <= '0;
      r_q    <= '0;
      r_m    <= '0;
      r_qn1  <= 1'b0;
      r_cnt  <= '0;
      r_mode <= MODE_MUL;
    end else if (w_do_comp) begin
      r_err <= 1'b0;
      case (bus.op)
        OP_NOP: ;
        OP_ADD: begin
          r_r0  <= w_sum;
          r_err <= w_add_ovf;
        end
        OP_SUB: begin
          r_r0  <= w_dif;
          r_err <= w_sub_ovf;
        end
        OP_SWAP: begin
          r_r0 <= r_r1;
          r_r1 <= r_r0;
        end
        OP_MUL, OP_DIV: begin
          if (w_iter_op) begin
            r_a    <= '0;
            r_q    <= r_r0;
            r_m    <= r_r1;
            r_qn1  <= 1'b0;
            r_cnt  <= CNT_W'(WIDTH);
            r_mode <= (bus.op == OP_MUL) ? MODE_MUL : MODE_DIV;
          end else begin
            r_err <= 1'b1;
          end
        end
        OP_CLRR: begin
          r_r0 <= '0;
          r_r1 <= '0;
        end
        OP_RSV:  r_err <= 1'b1;
        default: ;
      endcase
    end else if (w_do_load) begin
      if (bus.op[0]) r_r1 <= bus.data_in;
      else           r_r0 <= bus.data_in;
    end else if (r_state == ITER) begin
      r_a   <= w_a_nxt;
      r_q   <= w_q_nxt;
      r_qn1 <= w_qn1_nxt;
      r_cnt <= r_cnt - CNT_W'(1);
      // User registers only see the final step, never intermediate A/Q.
      if (w_last) begin
        if (r_mode == MODE_MUL) begin
          r_r1 <= w_a_nxt[WIDTH-1:0];
          r_r0 <= w_q_nxt;
        end else begin
          r_r0 <= w_q_nxt;
          r_r1 <= w_a_nxt[WIDTH-1:0];
        end
      end
    end
  end

endmodule
